usb_packet_decoder: RTL and testbench

//  Receive-side USB packet parser between the ULPI receive byte stream and endpoint_ctrl.

---
 rtl/usb_packet_decoder_pkg.sv | 43 ++++
 rtl/usb_packet_decoder_crc.sv | 33 +++
 rtl/usb_packet_decoder.sv | 166 ++++++++++++++++
 tb/tb_usb_packet_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_packet_decoder_pkg.sv
// Shared USB receive definitions: PID codes, CRC parameters, decoder states and PID classifier.
package usb_packet_decoder_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_DATA2 = 8'h87;
    localparam logic [7:0] PID_MDATA = 8'h0F;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_NYET  = 8'h96;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_RES   = 5'b01100;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_RES  = 16'h800D;

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DROP
    } state_t;

    // Maps a PID byte to the state that handles the rest of its packet.
    function automatic state_t pid_class(input logic [7:0] p);
        state_t s;
        s = S_DROP;
        if (p[7:4] == ~p[3:0]) begin
            case (p)
                PID_OUT, PID_IN, PID_SOF, PID_SETUP:         s = S_TOKEN;
                PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:  s = S_DATA;
                PID_ACK, PID_NAK, PID_STALL, PID_NYET:       s = S_HSK;
                default:                                     s = S_DROP;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/usb_packet_decoder_crc.sv
// Byte-wide USB CRC (CRC5 or CRC16), bits consumed LSB-first; residual is checked by the caller.
module usb_crc
    import usb_packet_decoder_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             en,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] crc
);
    localparam logic [WIDTH-1:0] POLY = (WIDTH == 5) ? WIDTH'(CRC5_POLY) : WIDTH'(CRC16_POLY);
    localparam logic [WIDTH-1:0] INIT = (WIDTH == 5) ? WIDTH'(CRC5_INIT) : WIDTH'(CRC16_INIT);

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = crc;
        for (int i = 0; i < 8; i++) begin
            if (nxt[WIDTH-1] ^ data[i]) nxt = {nxt[WIDTH-2:0], 1'b0} ^ POLY;
            else                        nxt = {nxt[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      crc <= INIT;
        else if (clear) crc <= INIT;
        else if (en)    crc <= nxt;
    end

endmodule

// File: rtl/usb_packet_decoder.sv
// Receive-side USB packet parser: validates PID/CRC, emits token/SOF/handshake strobes and
// streams data payload with the trailing CRC16 bytes held back.
module usb_packet_decoder
    import usb_packet_decoder_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  rx_data,
    input  logic        rx_strb,
    input  logic        rx_active,
    input  logic        rx_err,
    output logic [23:0] token_out,
    output logic        token_strb,
    output logic [10:0] sof_frame,
    output logic        sof_strb,
    output logic [7:0]  pid,
    output logic        hsk_strb,
    output logic [7:0]  data_out,
    output logic        data_strb,
    output logic        data_end,
    output logic        data_fail
);
    localparam int             CW    = $clog2(MAX_PAYLOAD + 3) + 1;
    localparam logic [CW-1:0]  LIMIT = CW'(MAX_PAYLOAD + 2);
    localparam logic [CW-1:0]  TWO   = CW'(2);

    state_t        state, cur;
    logic [7:0]    pid_byte, hold0, hold1;
    logic [CW-1:0] cnt;
    logic          fresh;
    logic [4:0]    crc5;
    logic [15:0]   crc16;
    logic          byte_in;

    // In S_PID the packet class is already known from the latched PID, so any byte arriving
    // that cycle is handled as if the class state had already been entered.
    always_comb begin
        cur = state;
        if (state == S_PID) cur = pid_class(pid_byte);
    end

    assign byte_in = rx_active && rx_strb && (state != S_IDLE);

    usb_crc #(.WIDTH(5)) u_crc5 (
        .clk(clk), .nrst(nrst), .clear(state == S_IDLE),
        .en(byte_in && cur == S_TOKEN), .data(rx_data), .crc(crc5)
    );

    usb_crc #(.WIDTH(16)) u_crc16 (
        .clk(clk), .nrst(nrst), .clear(state == S_IDLE),
        .en(byte_in && cur == S_DATA), .data(rx_data), .crc(crc16)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            fresh      <= 1'b1;
            pid_byte   <= '0;
            hold0      <= '0;
            hold1      <= '0;
            cnt        <= '0;
            token_out  <= '0;
            token_strb <= 1'b0;
            sof_frame  <= '0;
            sof_strb   <= 1'b0;
            pid        <= '0;
            hsk_strb   <= 1'b0;
            data_out   <= '0;
            data_strb  <= 1'b0;
            data_end   <= 1'b0;
            data_fail  <= 1'b0;
        end else begin
            token_strb <= 1'b0;
            sof_strb   <= 1'b0;
            hsk_strb   <= 1'b0;
            data_strb  <= 1'b0;
            data_end   <= 1'b0;
            data_fail  <= 1'b0;
            fresh      <= 1'b0;

            // Coming out of reset inside a packet: discard its remainder.
            if (fresh && rx_active) begin
                state <= S_DROP;
            end else if (state == S_IDLE) begin
                if (rx_active && rx_strb) begin
                    pid_byte <= rx_data;
                    cnt      <= '0;
                    state    <= S_PID;
                end
            end else if (!rx_active) begin
                state <= S_IDLE;
                case (cur)
                    S_TOKEN: begin
                        if (cnt == TWO && crc5 == CRC5_RES) begin
                            if (pid_byte == PID_SOF) begin
                                sof_frame <= {hold0[2:0], hold1};
                                sof_strb  <= 1'b1;
                            end else begin
                                token_out  <= {hold0, hold1, pid_byte};
                                token_strb <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (cnt >= TWO && crc16 == CRC16_RES) data_end  <= 1'b1;
                        else                                  data_fail <= 1'b1;
                    end
                    S_HSK: begin
                        if (cnt == '0) begin
                            pid      <= pid_byte;
                            hsk_strb <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                if (state == S_PID) begin
                    state <= cur;
                    if (cur == S_DATA) pid <= pid_byte;
                end
                case (cur)
                    S_TOKEN: begin
                        if (rx_err) begin
                            state <= S_DROP;
                        end else if (rx_strb) begin
                            if (cnt == TWO) begin
                                state <= S_DROP;
                            end else begin
                                hold1 <= hold0;
                                hold0 <= rx_data;
                                cnt   <= cnt + 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_err) begin
                            data_fail <= 1'b1;
                            state     <= S_DROP;
                        end else if (rx_strb) begin
                            if (cnt == LIMIT) begin
                                data_fail <= 1'b1;
                                state     <= S_DROP;
                            end else begin
                                // Two-byte hold-back keeps the CRC16 bytes off data_out.
                                if (cnt >= TWO) begin
                                    data_out  <= hold1;
                                    data_strb <= 1'b1;
                                end
                                hold1 <= hold0;
                                hold0 <= rx_data;
                                cnt   <= cnt + 1'b1;
                            end
                        end
                    end
                    S_HSK: begin
                        if (rx_err || rx_strb) state <= S_DROP;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Scoreboard bench for usb_packet_decoder: expected strobe events are queued as packets are
// driven and matched in order against what the decoder emits.
module tb_usb_packet_decoder;
    localparam int MAXP = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [5:0]  kind;   // {token, sof, hsk, data, end, fail}
        logic [23:0] val;
    } ev_t;

    localparam logic [5:0] K_TOK = 6'b100000;
    localparam logic [5:0] K_SOF = 6'b010000;
    localparam logic [5:0] K_HSK = 6'b001000;
    localparam logic [5:0] K_DAT = 6'b000100;
    localparam logic [5:0] K_END = 6'b000010;
    localparam logic [5:0] K_FAI = 6'b000001;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  rx_data;
    logic        rx_strb, rx_active, rx_err;
    logic [23:0] token_out;
    logic        token_strb;
    logic [10:0] sof_frame;
    logic        sof_strb;
    logic [7:0]  pid;
    logic        hsk_strb;
    logic [7:0]  data_out;
    logic        data_strb, data_end, data_fail;

    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];

    usb_packet_decoder #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_strb(rx_strb),
        .rx_active(rx_active), .rx_err(rx_err), .token_out(token_out),
        .token_strb(token_strb), .sof_frame(sof_frame), .sof_strb(sof_strb),
        .pid(pid), .hsk_strb(hsk_strb), .data_out(data_out), .data_strb(data_strb),
        .data_end(data_end), .data_fail(data_fail)
    );

    always #5 clk = ~clk;

    // Output monitor: each strobe cycle is one scoreboard comparison.
    always @(negedge clk) begin
        ev_t got, exp;
        if (nrst === 1'b1 && (token_strb | sof_strb | hsk_strb | data_strb | data_end | data_fail)) begin
            got.kind = {token_strb, sof_strb, hsk_strb, data_strb, data_end, data_fail};
            got.val  = token_strb ? token_out : sof_strb ? {13'd0, sof_frame} :
                       (hsk_strb | data_end) ? {16'd0, pid} : data_strb ? {16'd0, data_out} : 24'd0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL event: got kind=%b val=%h, expected no event", got.kind, got.val);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event: got kind=%b val=%h, expected kind=%b val=%h",
                             got.kind, got.val, exp.kind, exp.val);
                end
            end
        end
    end

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'h05;
        end
        return c;
    endfunction

    task automatic push(input logic [5:0] k, input logic [23:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_strb = 1'b1;
        @(posedge clk); #1;
        rx_strb = 1'b0;
    endtask

    // err_after = index of the byte after which rx_err pulses for one cycle (-1: none).
    task automatic send_pkt(input bq_t bytes, input int err_after);
        rx_active = 1'b1;
        @(posedge clk); #1;
        foreach (bytes[i]) begin
            rx_byte(bytes[i]);
            if (i == err_after) begin
                rx_err = 1'b1;
                @(posedge clk); #1;
                rx_err = 1'b0;
            end
        end
        @(posedge clk); #1;
        rx_active = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset;
        nrst = 1'b0; rx_data = '0; rx_strb = 1'b0; rx_active = 1'b0; rx_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({token_out, sof_frame, pid, data_out} !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h, required 0", {token_out, sof_frame, pid, data_out});
        end
        checks++;
        if ({token_strb, sof_strb, hsk_strb, data_strb, data_end, data_fail} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 000000",
                     {token_strb, sof_strb, hsk_strb, data_strb, data_end, data_fail});
        end
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_token;
        push(K_TOK, 24'h10002D);
        send_pkt('{8'h2D, 8'h00, 8'h10}, -1);
        drained("token");
        send_pkt('{8'h2D, 8'h00, 8'h10, 8'h00}, -1);
        drained("token_extra_byte");
    endtask

    task automatic test_data;
        bq_t pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        foreach (pl[i]) push(K_DAT, {16'd0, pl[i]});
        push(K_END, 24'h0000C3);
        send_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, -1);
        drained("data_good");
        checks++;
        if (pid !== 8'hC3) begin
            errors++;
            $display("FAIL data_pid: got %h, required c3", pid);
        end
    endtask

    task automatic test_data_errors;
        bq_t pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        foreach (pl[i]) push(K_DAT, {16'd0, pl[i]});
        push(K_FAI, 24'd0);
        send_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95}, -1);
        drained("data_bad_crc");
        push(K_DAT, 24'h000080);
        push(K_FAI, 24'd0);
        send_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 3);
        drained("data_rx_err");
        // MAXP+1 payload bytes: the byte past the limit aborts the packet.
        for (int i = 0; i < MAXP; i++) push(K_DAT, 24'(i + 1));
        push(K_FAI, 24'd0);
        send_pkt('{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h09, 8'h0A, 8'h0B}, -1);
        drained("data_overflow");
    endtask

    task automatic test_short;
        push(K_END, 24'h00004B);
        send_pkt('{8'h4B, 8'h00, 8'h00}, -1);
        drained("zero_length");
        checks++;
        if (pid !== 8'h4B) begin
            errors++;
            $display("FAIL zlp_pid: got %h, required 4b", pid);
        end
        push(K_HSK, 24'h0000D2);
        send_pkt('{8'hD2}, -1);
        drained("handshake");
        checks++;
        if (pid !== 8'hD2) begin
            errors++;
            $display("FAIL hsk_pid: got %h, required d2", pid);
        end
        send_pkt('{8'hD3}, -1);
        drained("bad_pid");
        send_pkt('{8'hD2, 8'h00}, -1);
        drained("hsk_long");
    endtask

    task automatic test_sof;
        logic [10:0] frame = 11'h3A5;
        logic [7:0]  b1, b2, good;
        logic [4:0]  c;
        good = '0;
        b1   = frame[7:0];
        for (int k = 0; k < 32; k++) begin
            b2 = {k[4:0], frame[10:8]};
            c  = crc5_byte(crc5_byte(5'h1F, b1), b2);
            if (c == 5'b01100) good = b2;
        end
        push(K_SOF, {13'd0, frame});
        send_pkt('{8'hA5, b1, good}, -1);
        drained("sof");
        send_pkt('{8'hA5, b1, good ^ 8'h80}, -1);
        drained("sof_bad_crc");
    endtask

    task automatic test_reset_mid;
        rx_active = 1'b1;
        @(posedge clk); #1;
        push(K_DAT, 24'h000080);
        rx_byte(8'hC3); rx_byte(8'h80); rx_byte(8'h06); rx_byte(8'h00);
        @(negedge clk); #1;
        nrst = 1'b0;
        #1;
        checks++;
        if ({token_out, sof_frame, pid, data_out, token_strb, sof_strb, hsk_strb,
             data_strb, data_end, data_fail} !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs got %h, required 0",
                     {token_out, sof_frame, pid, data_out});
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'h00); rx_byte(8'h40);
        rx_byte(8'h00); rx_byte(8'hDD); rx_byte(8'h94);
        @(posedge clk); #1;
        rx_active = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drained("reset_mid_silence");
        push(K_TOK, 24'h10002D);
        send_pkt('{8'h2D, 8'h00, 8'h10}, -1);
        drained("after_reset");
    endtask

    initial begin
        test_reset();
        test_token();
        test_data();
        test_data_errors();
        test_short();
        test_sof();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
